// File: rtl/st7920_pkg.sv
// Shared definitions for the ST7920 bus responder: opcode masks, fill character,
// FSM state encoding, DDRAM geometry and the address-counter step rule.
package st7920_pkg;

  localparam int         DDRAM_DEPTH   = 64;
  localparam logic [7:0] FILL_CHAR     = 8'h20;

  localparam logic [7:0] OP_CLEAR      = 8'h01;
  localparam logic [7:0] HOME_MASK     = 8'hFE;
  localparam logic [7:0] HOME_VAL      = 8'h02;
  localparam logic [7:0] ENTRY_MASK    = 8'hFC;
  localparam logic [7:0] ENTRY_VAL     = 8'h04;
  localparam logic [7:0] DISPLAY_MASK  = 8'hF8;
  localparam logic [7:0] DISPLAY_VAL   = 8'h08;
  localparam logic [7:0] FUNCSET_MASK  = 8'hE0;
  localparam logic [7:0] FUNCSET_VAL   = 8'h20;
  localparam logic [7:0] SETDDRAM_MASK = 8'h80;
  localparam logic [7:0] SETDDRAM_VAL  = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  // AC is {word, half}; the word only steps when the half wraps back to 0.
  function automatic logic [5:0] ac_advance(input logic [5:0] ac, input logic id);
    logic [4:0] w_word;
    if (!ac[0]) begin
      return {ac[5:1], 1'b1};
    end
    w_word = id ? (ac[5:1] + 5'd1) : (ac[5:1] - 5'd1);
    return {w_word, 1'b0};
  endfunction

endpackage

// File: rtl/st7920_ddram.sv
// 64x8 DDRAM: port A write plus registered read, port B registered read only.
// Both reads are read-first, so a same-cycle write to the read address returns old data.
module st7920_ddram
  import st7920_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_a_we,
  input  logic [5:0] i_a_addr,
  input  logic [7:0] i_a_wdata,
  output logic [7:0] o_a_rdata,
  input  logic [5:0] i_b_addr,
  output logic [7:0] o_b_rdata
);

  logic [7:0] r_mem [DDRAM_DEPTH];
  logic [7:0] r_a_q;
  logic [7:0] r_b_q;

  always_ff @(posedge i_clk) begin
    if (i_a_we) begin
      r_mem[i_a_addr] <= i_a_wdata;
    end
    r_a_q <= r_mem[i_a_addr];
    r_b_q <= r_mem[i_b_addr];
  end

  assign o_a_rdata = r_a_q;
  assign o_b_rdata = r_b_q;

endmodule

// File: rtl/st7920_bus_rx.sv
// ST7920 8-bit parallel-bus panel emulator: decodes transfers on synchronized EN falls,
// effects land one cycle after detection; writes arriving while busy are dropped and flagged.
module st7920_bus_rx
  import st7920_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int BUSY_CMD_CYC = 3600,
  parameter int BUSY_CLR_CYC = 80000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [7:0] lcd_db_i,
  output logic [7:0] lcd_db_o,
  output logic       lcd_db_oe,
  output logic       busy,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       re_ext,
  output logic       err_busy,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data
);

  localparam int CNT_MAX = (BUSY_CLR_CYC > BUSY_CMD_CYC) ? BUSY_CLR_CYC : BUSY_CMD_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [SYNC_STAGES-1:0]      r_en_sync;
  logic [SYNC_STAGES-1:0]      r_rs_sync;
  logic [SYNC_STAGES-1:0]      r_rw_sync;
  logic [SYNC_STAGES-1:0][7:0] r_db_sync;
  logic                        r_en_d;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [6:0]  r_fill;
  logic [5:0]  r_ac;
  logic        r_id;
  logic        r_disp;
  logic        r_cursor;
  logic        r_blink;
  logic        r_re;
  logic        r_err;

  logic       w_en_s;
  logic       w_rs_s;
  logic       w_rw_s;
  logic [7:0] w_db_s;
  logic       w_fall;
  logic       w_status_rd;
  logic       w_busy;
  logic       w_accept;
  logic       w_reject;
  logic       w_is_clear;
  logic       w_filling;
  logic       w_we;
  logic [5:0] w_a_addr;
  logic [7:0] w_a_wdata;
  logic [7:0] w_a_rdata;

  assign w_en_s      = r_en_sync[SYNC_STAGES-1];
  assign w_rs_s      = r_rs_sync[SYNC_STAGES-1];
  assign w_rw_s      = r_rw_sync[SYNC_STAGES-1];
  assign w_db_s      = r_db_sync[SYNC_STAGES-1];
  assign w_fall      = r_en_d & ~w_en_s;
  assign w_status_rd = ~w_rs_s & w_rw_s;
  assign w_busy      = (r_state != ST_IDLE);
  assign w_accept    = w_fall & ~w_status_rd & ~w_busy;
  assign w_reject    = w_fall & ~w_status_rd & w_busy;
  assign w_is_clear  = ~w_rs_s & ~w_rw_s & ~r_re & (w_db_s == OP_CLEAR);
  assign w_filling   = (r_state == ST_CLEAR) & ~r_fill[6];

  // The reset cycle itself must not write, so an aborted Clear stops cleanly.
  assign w_we      = ~rst & (w_filling | (w_accept & w_rs_s & ~w_rw_s));
  assign w_a_addr  = (r_state == ST_CLEAR) ? r_fill[5:0] : r_ac;
  assign w_a_wdata = (r_state == ST_CLEAR) ? FILL_CHAR : w_db_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_sync <= '0;
      r_rs_sync <= '0;
      r_rw_sync <= '0;
      r_db_sync <= '0;
      r_en_d    <= 1'b0;
    end else begin
      r_en_sync <= {r_en_sync[SYNC_STAGES-2:0], lcd_en};
      r_rs_sync <= {r_rs_sync[SYNC_STAGES-2:0], lcd_rs};
      r_rw_sync <= {r_rw_sync[SYNC_STAGES-2:0], lcd_rw};
      r_db_sync <= {r_db_sync[SYNC_STAGES-2:0], lcd_db_i};
      r_en_d    <= w_en_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = w_is_clear ? ST_CLEAR : ST_EXEC;
      ST_EXEC:  if (r_cnt == '0) w_state_nxt = ST_IDLE;
      ST_CLEAR: if (r_cnt == '0) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_fill   <= '0;
      r_ac     <= '0;
      r_id     <= 1'b1;
      r_disp   <= 1'b0;
      r_cursor <= 1'b0;
      r_blink  <= 1'b0;
      r_re     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt  <= w_is_clear ? CW'(BUSY_CLR_CYC - 1) : CW'(BUSY_CMD_CYC - 1);
        r_fill <= '0;
      end else begin
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        if (w_filling)   r_fill <= r_fill + 1'b1;
      end
      if (w_reject) r_err <= 1'b1;
      if (w_accept) begin
        if (w_rs_s) begin
          r_ac <= ac_advance(r_ac, r_id);
        end else if (r_re) begin
          // Extended set: only Function Set is honoured, to allow leaving it.
          if ((w_db_s & FUNCSET_MASK) == FUNCSET_VAL) r_re <= w_db_s[2];
        end else if (w_db_s == OP_CLEAR) begin
          r_ac <= '0;
          r_id <= 1'b1;
        end else if ((w_db_s & HOME_MASK) == HOME_VAL) begin
          r_ac <= '0;
        end else if ((w_db_s & ENTRY_MASK) == ENTRY_VAL) begin
          r_id <= w_db_s[1];
        end else if ((w_db_s & DISPLAY_MASK) == DISPLAY_VAL) begin
          r_disp   <= w_db_s[2];
          r_cursor <= w_db_s[1];
          r_blink  <= w_db_s[0];
        end else if ((w_db_s & FUNCSET_MASK) == FUNCSET_VAL) begin
          r_re <= w_db_s[2];
        end else if ((w_db_s & SETDDRAM_MASK) == SETDDRAM_VAL) begin
          r_ac <= {w_db_s[4:0], 1'b0};
        end
      end
    end
  end

  st7920_ddram u_ddram (
    .i_clk     (clk),
    .i_a_we    (w_we),
    .i_a_addr  (w_a_addr),
    .i_a_wdata (w_a_wdata),
    .o_a_rdata (w_a_rdata),
    .i_b_addr  (rd_addr),
    .o_b_rdata (rd_data)
  );

  assign lcd_db_oe = w_en_s & w_rw_s;
  assign lcd_db_o  = !lcd_db_oe ? 8'h00 :
                     w_rs_s     ? w_a_rdata : {w_busy, 2'b00, r_ac[5:1]};
  assign busy      = w_busy;
  assign disp_on   = r_disp;
  assign cursor_on = r_cursor;
  assign blink_on  = r_blink;
  assign re_ext    = r_re;
  assign err_busy  = r_err;

endmodule

// File: tb/tb_st7920_bus_rx.sv
// Bench for st7920_bus_rx: transaction-level panel model plus per-cycle flag compare
// and directed literal checks on status/read values and DDRAM contents.
module tb_st7920_bus_rx;

  localparam int SYNC = 2;
  localparam int CMD  = 20;
  localparam int CLR  = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic       lcd_en = 1'b0;
  logic [7:0] lcd_db_i = 8'h00;
  logic [7:0] lcd_db_o;
  logic       lcd_db_oe;
  logic       busy, disp_on, cursor_on, blink_on, re_ext, err_busy;
  logic [5:0] rd_addr = 6'd0;
  logic [7:0] rd_data;

  st7920_bus_rx #(
    .SYNC_STAGES  (SYNC),
    .BUSY_CMD_CYC (CMD),
    .BUSY_CLR_CYC (CLR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_en    (lcd_en),
    .lcd_db_i  (lcd_db_i),
    .lcd_db_o  (lcd_db_o),
    .lcd_db_oe (lcd_db_oe),
    .busy      (busy),
    .disp_on   (disp_on),
    .cursor_on (cursor_on),
    .blink_on  (blink_on),
    .re_ext    (re_ext),
    .err_busy  (err_busy),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Panel model: byte-addressed DDRAM, AC as a byte index 0..63.
  logic [7:0] m_mem [64];
  int m_ac;
  int m_busy_left;
  bit m_id, m_disp, m_cur, m_blink, m_re, m_err, m_clr_pending;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ac = 0; m_id = 1'b1; m_disp = 1'b0; m_cur = 1'b0; m_blink = 1'b0;
    m_re = 1'b0; m_err = 1'b0; m_busy_left = 0; m_clr_pending = 1'b0;
  endtask

  task automatic model_apply(input logic rs, input logic rw, input logic [7:0] db, input bit acc);
    int d;
    d = int'(db);
    if (!rs && rw) return;
    if (!acc) begin
      m_err = 1'b1;
      return;
    end
    m_busy_left = CMD;
    if (rs) begin
      if (!rw) m_mem[m_ac] = db;
      if (m_ac % 2 == 0) m_ac = m_ac + 1;
      else m_ac = (((m_ac / 2) + (m_id ? 1 : 31)) % 32) * 2;
    end else if (m_re) begin
      if (d >= 32 && d <= 63) m_re = db[2];
    end else if (d == 1) begin
      m_busy_left = CLR; m_clr_pending = 1'b1; m_ac = 0; m_id = 1'b1;
    end else if (d == 2 || d == 3) m_ac = 0;
    else if (d >= 4 && d <= 7) m_id = db[1];
    else if (d >= 8 && d <= 15) begin
      m_disp = db[2]; m_cur = db[1]; m_blink = db[0];
    end else if (d >= 32 && d <= 63) m_re = db[2];
    else if (d >= 128) m_ac = (d % 32) * 2;
  endtask

  always @(posedge clk) if (m_busy_left > 0) m_busy_left--;

  always @(negedge clk) begin
    if (chk_en) begin
      logic [5:0] e;
      e = {m_busy_left > 0, m_disp, m_cur, m_blink, m_re, m_err};
      chk("flags{busy,disp,cur,blink,re,err}",
          {26'd0, busy, disp_on, cursor_on, blink_on, re_ext, err_busy}, {26'd0, e});
    end
  end

  // Entered and left at #1 after a rising edge.
  task automatic xfer(input logic rs, input logic rw, input logic [7:0] db, output logic [7:0] obs);
    bit acc;
    logic [7:0] e;
    obs = 8'h00;
    lcd_rs = rs; lcd_rw = rw; lcd_db_i = db; lcd_en = 1'b1;
    repeat (SYNC - 1) @(posedge clk);
    @(negedge clk);
    chk("oe_before_sync", lcd_db_oe, 0);
    @(posedge clk);
    @(negedge clk);
    chk("oe", lcd_db_oe, rw);
    if (rw) begin
      e = rs ? m_mem[m_ac] : {m_busy_left > 0, 2'b00, 5'(m_ac / 2)};
      obs = lcd_db_o;
      chk(rs ? "data_read_bus" : "status_read_bus", lcd_db_o, e);
    end
    @(posedge clk); #1 lcd_en = 1'b0;
    repeat (SYNC) @(posedge clk);
    #1 acc = (m_busy_left == 0);
    @(posedge clk);
    #1 model_apply(rs, rw, db, acc);
  endtask

  task automatic wait_idle();
    int k;
    while (m_busy_left > 0) begin
      @(posedge clk); #1;
    end
    k = 0;
    while (busy !== 1'b0 && k < 8) begin
      @(posedge clk); #1; k++;
    end
    chk("busy_drops", busy, 0);
    if (m_clr_pending) begin
      for (int i = 0; i < 64; i++) m_mem[i] = 8'h20;
      m_clr_pending = 1'b0;
    end
  endtask

  task automatic wr(input logic rs, input logic [7:0] db);
    logic [7:0] o;
    xfer(rs, 1'b0, db, o);
    wait_idle();
  endtask

  task automatic rd_get(input int a, output logic [7:0] v);
    rd_addr = 6'(a);
    @(posedge clk);
    @(negedge clk);
    v = rd_data;
    @(posedge clk); #1;
  endtask

  task automatic dump_check();
    logic [7:0] v;
    for (int i = 0; i < 64; i++) begin
      rd_get(i, v);
      chk($sformatf("ddram[%0d]", i), v, m_mem[i]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 model_reset();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] o;
    logic [7:0] v;
    for (int i = 0; i < 64; i++) m_mem[i] = 8'hxx;
    repeat (3) @(posedge clk);
    #1 model_reset();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_db_o", lcd_db_o, 8'h00);
    chk("reset_db_oe", lcd_db_oe, 0);
    chk("reset_busy", busy, 0);

    // Init sequence
    wr(0, 8'h30); wr(0, 8'h30); wr(0, 8'h0E); wr(0, 8'h01);
    wr(0, 8'h06); wr(0, 8'h80); wr(1, 8'hA3); wr(1, 8'hC1);
    chk("init_disp_cur_blink", {disp_on, cursor_on, blink_on}, 3'b110);
    chk("init_err", err_busy, 0);
    xfer(0, 1, 8'h00, o);
    chk("init_status", o, 8'h01);
    rd_get(0, v); chk("init_ddram0", v, 8'hA3);
    rd_get(1, v); chk("init_ddram1", v, 8'hC1);
    dump_check();

    // Write while busy is dropped
    xfer(0, 0, 8'h0C, o);
    xfer(0, 0, 8'h01, o);
    wait_idle();
    chk("busy_drop_err", err_busy, 1);
    chk("busy_drop_disp", {disp_on, cursor_on, blink_on}, 3'b100);
    rd_get(0, v); chk("busy_drop_ddram0", v, 8'hA3);

    // Word-address wrap 31 -> 0
    wr(0, 8'h9F);
    wr(1, 8'h11); wr(1, 8'h12); wr(1, 8'h13); wr(1, 8'h14);
    xfer(0, 1, 8'h00, o);
    chk("wrap_status", o, 8'h01);
    rd_get(62, v); chk("wrap_ddram62", v, 8'h11);
    rd_get(63, v); chk("wrap_ddram63", v, 8'h12);
    rd_get(0, v);  chk("wrap_ddram0", v, 8'h13);
    rd_get(1, v);  chk("wrap_ddram1", v, 8'h14);

    // Status during and after Clear
    xfer(0, 0, 8'h01, o);
    xfer(0, 1, 8'h00, o);
    chk("clear_status_busy", o, 8'h80);
    wait_idle();
    xfer(0, 1, 8'h00, o);
    chk("clear_status_done", o, 8'h00);
    dump_check();
    rd_get(37, v); chk("clear_ddram37", v, 8'h20);

    // Data read advances AC
    wr(0, 8'h85); wr(1, 8'h41); wr(1, 8'h42); wr(0, 8'h85);
    xfer(1, 1, 8'h00, o); chk("data_read_1", o, 8'h41); wait_idle();
    xfer(1, 1, 8'h00, o); chk("data_read_2", o, 8'h42); wait_idle();

    // Reset 30 cycles into a Clear
    wr(0, 8'h80);
    for (int i = 0; i < 64; i++) wr(1, 8'(i) ^ 8'hA5);
    xfer(0, 0, 8'h01, o);
    repeat (30) @(posedge clk);
    #1 do_reset();
    for (int i = 0; i < 30; i++) m_mem[i] = 8'h20;
    chk("abort_busy", busy, 0);
    xfer(0, 1, 8'h00, o);
    chk("abort_status", o, 8'h00);
    dump_check();
    rd_get(29, v); chk("abort_ddram29", v, 8'h20);
    rd_get(30, v); chk("abort_ddram30", v, 8'hBB);
    rd_get(63, v); chk("abort_ddram63", v, 8'h9A);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
